seq_comparator_nbit: RTL and testbench
======================================

SEQ_COMPARATOR_NBIT -- requirements
Module: seq_comparator_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits; legal range 1..32.
REQ-002 The block SHALL have parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to compare the values present on a and b.
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in CMP.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking new g/l/e results.
REQ-010 The block SHALL have port g, output, 1 bit: registered result, a > b.
REQ-011 The block SHALL have port l, output, 1 bit: registered result, a < b.
REQ-012 The block SHALL have port e, output, 1 bit: registered result, a == b.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CMP and DONE.
REQ-014 In IDLE, a rising edge sampling start=1 SHALL latch a and b into internal shift registers, load the bit counter with WIDTH-1 and enter CMP; call this edge T0.
REQ-015 In CMP, the block SHALL examine one bit pair per cycle, MSB first, at indices WIDTH-1 down to 0.
REQ-016 In CMP, the first differing bit pair SHALL set a sticky decision, and later bits SHALL NOT change it.
REQ-017 If the first differing pair is (1,0), the decision SHALL be a>b; if it is (0,1), the decision SHALL be a<b.
REQ-018 When SIGNED=1 and the first difference is at index WIDTH-1, the sense SHALL be inverted: a bit of 1 means negative, so (1,0) gives a<b.
REQ-019 If no bit pair differs, the decision SHALL be a==b.
REQ-020 CMP SHALL last exactly WIDTH cycles, with no early termination; the FSM SHALL enter DONE at edge T0+WIDTH.
REQ-021 At edge T0+WIDTH, g, l and e SHALL be loaded, with exactly one of them equal to 1.
REQ-022 At edge T0+WIDTH, done SHALL go high.
REQ-023 DONE SHALL last one cycle, after which the FSM SHALL return to IDLE at edge T0+WIDTH+1, where done SHALL fall.
REQ-024 busy SHALL be 1 exactly in CMP: it rises at T0 and falls at T0+WIDTH.
REQ-025 g, l and e SHALL hold their last values until the next DONE entry.
REQ-026 start SHALL be ignored in CMP and in DONE, and SHALL NOT cause queuing or restart.
REQ-027 Changes on a and b after T0 SHALL NOT affect the result in progress.
REQ-028 start held continuously high SHALL produce back-to-back compares, each occupying WIDTH+2 cycles from start edge to the next start edge.
REQ-029 With WIDTH=1 and SIGNED=1, the operands SHALL be treated as values 0 and -1, per REQ-018.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, force IDLE and clear busy, done, g, l and e to 0.
REQ-031 rst_n=0 SHALL also clear the shift registers, the counter and the sticky decision.
REQ-032 A reset during CMP or DONE SHALL discard the compare in progress, and no done pulse SHALL follow for it.
REQ-033 After rst_n rises, the first start sampled in IDLE SHALL behave per REQ-014 to REQ-024.
REQ-034 After reset and before the first DONE, g=l=e=0 SHALL hold, which is the only legal all-zero result state.

Verification
REQ-035 The bench SHALL cover: WIDTH=8, SIGNED=0, a=0xA5, b=0x5A, start pulse at T0 -> busy high T0..T0+8, done high for 1 cycle from T0+8, g=1, l=0, e=0.
REQ-036 The bench SHALL cover: WIDTH=8, a=b=0x3C -> e=1, g=l=0 at T0+8; then a=0x3C, b=0x3D -> l=1 at the next done.
REQ-037 The bench SHALL cover: WIDTH=8, a=0x80, b=0x7F -> SIGNED=1 gives l=1; SIGNED=0 gives g=1; a=0xFF, b=0xFE with SIGNED=1 gives g=1.
REQ-038 The bench SHALL cover: start pulsed and a/b changed to 0x00 at T0+3 during CMP -> ignored; the result reflects the operands latched at T0; exactly one done pulse occurs.
REQ-039 The bench SHALL cover: rst_n driven low asynchronously mid-cycle at T0+4 -> busy=done=g=l=e=0 immediately with no done afterwards; after release, a=0x01, b=0x02 -> l=1.
REQ-040 The bench SHALL cover: start held high across three compares -> done pulses spaced exactly 10 cycles apart for WIDTH=8, and results held between pulses.

Source files
------------

// File: rtl/seq_comparator_nbit.sv
// Bit-serial magnitude comparator: latches two operands on start, walks them
// MSB first one bit per cycle, and reports a registered g/l/e result with a done pulse.
module seq_comparator_nbit #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             gt_q, gt_d;
  logic             g_q, g_d;
  logic             l_q, l_d;
  logic             e_q, e_d;

  logic bit_a, bit_b, msb_inv, dec_now, gt_now;

  // The sign bit carries inverted weight in two's complement, so a 1 there
  // marks the smaller operand.
  always_comb begin
    bit_a   = a_sh_q[WIDTH-1];
    bit_b   = b_sh_q[WIDTH-1];
    msb_inv = SIGNED && (cnt_q == CW'(WIDTH-1));
    dec_now = dec_q | (bit_a ^ bit_b);
    gt_now  = dec_q ? gt_q : (bit_a ^ msb_inv);
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    gt_d    = gt_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cnt_d   = CW'(WIDTH-1);
          dec_d   = 1'b0;
          gt_d    = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        dec_d  = dec_now;
        gt_d   = gt_now;
        if (cnt_q == '0) begin
          g_d     = dec_now & gt_now;
          l_d     = dec_now & ~gt_now;
          e_d     = ~dec_now;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      gt_q    <= gt_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
    end
  end

  assign busy    = (state_q == S_CMP);
  assign done    = (state_q == S_DONE);
  assign g       = g_q;
  assign l       = l_q;
  assign e       = e_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_comparator_nbit.sv
// Bench for seq_comparator_nbit: an unsigned and a signed 8-bit instance share
// stimulus and are checked every cycle against an arithmetic reference.
module tb_seq_comparator_nbit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic busy0, done0, g0, l0, e0;
  logic busy1, done1, g1, l1, e1;
  logic [1:0] st0, st1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int done_cnt = 0;
  int done_times[$];
  logic [2:0] exp_q[$];

  // reference state: edges since the accepted start, -1 when free
  int         m_k = -1;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2:0] m_res0 = 3'b000, m_res1 = 3'b000;

  seq_comparator_nbit #(.WIDTH(W), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .g(g0), .l(l0), .e(e0), .state_o(st0)
  );

  seq_comparator_nbit #(.WIDTH(W), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .g(g1), .l(l1), .e(e1), .state_o(st1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // result as {g,l,e} from plain integer comparison
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (sgn) begin
      if (x[W-1]) xi -= (1 << W);
      if (y[W-1]) yi -= (1 << W);
    end
    if (xi > yi) return 3'b100;
    if (xi < yi) return 3'b010;
    return 3'b001;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = -1;
      m_res0 = 3'b000;
      m_res1 = 3'b000;
      exp_q.delete();
    end else if (m_k < 0) begin
      if (start) begin
        m_k = 0;
        m_a = a;
        m_b = b;
        exp_q.push_back(ref_cmp(a, b, 1'b0));
      end
    end else begin
      m_k++;
      if (m_k == W) begin
        m_res0 = ref_cmp(m_a, m_b, 1'b0);
        m_res1 = ref_cmp(m_a, m_b, 1'b1);
      end else if (m_k == W + 1) begin
        m_k = -1;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy0", 32'(busy0), 32'(m_k >= 0 && m_k < W));
      check("done0", 32'(done0), 32'(m_k == W));
      check("gle0",  32'({g0, l0, e0}), 32'(m_res0));
      check("busy1", 32'(busy1), 32'(m_k >= 0 && m_k < W));
      check("done1", 32'(done1), 32'(m_k == W));
      check("gle1",  32'({g1, l1, e1}), 32'(m_res1));
      if (done0) begin
        done_cnt++;
        done_times.push_back(cyc);
        if (exp_q.size() == 0) check("done_unexpected", 32'(1), 32'(0));
        else check("sb_result0", 32'({g0, l0, e0}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;           // T0 has just happened
    start = 1'b0;
    lat = 0;
    while (!done0 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, d0, n, guard;

    // reset
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",  32'(busy0 | busy1), 32'(0));
    check("rst_done",  32'(done0 | done1), 32'(0));
    check("rst_gle0",  32'({g0, l0, e0}), 32'(0));
    check("rst_gle1",  32'({g1, l1, e1}), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2);
    check("idle_gle0_allzero", 32'({g0, l0, e0}), 32'(0));

    // 0xA5 vs 0x5A: latency, busy window, result
    run_cmp(8'hA5, 8'h5A, lat);
    check("lat_a5", 32'(lat), 32'(W));
    check("a5_u0_g", 32'({g0, l0, e0}), 32'(3'b100));
    check("a5_u1_l", 32'({g1, l1, e1}), 32'(3'b010));
    idle_cycles(1);
    check("a5_done_fell", 32'(done0), 32'(0));

    run_cmp(8'h3C, 8'h3C, lat);
    check("eq_3c", 32'({g0, l0, e0}), 32'(3'b001));
    run_cmp(8'h3C, 8'h3D, lat);
    check("lt_3d", 32'({g0, l0, e0}), 32'(3'b010));

    run_cmp(8'h80, 8'h7F, lat);
    check("80_u0", 32'({g0, l0, e0}), 32'(3'b100));
    check("80_u1", 32'({g1, l1, e1}), 32'(3'b010));
    run_cmp(8'hFF, 8'hFE, lat);
    check("ff_u1", 32'({g1, l1, e1}), 32'(3'b100));
    check("ff_u0", 32'({g0, l0, e0}), 32'(3'b100));
    run_cmp(8'h01, 8'h81, lat);
    check("01_u1_msb_g", 32'({g1, l1, e1}), 32'(3'b100));

    // start and operand change during CMP are ignored
    idle_cycles(2);
    d0 = done_cnt;
    start = 1'b1; a = 8'hC3; b = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'h00; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(14);
    check("mid_one_done", 32'(done_cnt - d0), 32'(1));
    check("mid_u0", 32'({g0, l0, e0}), 32'(3'b100));
    check("mid_u1", 32'({g1, l1, e1}), 32'(3'b010));

    // asynchronous reset in the middle of a compare
    start = 1'b1; a = 8'h77; b = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy0 | busy1), 32'(0));
    check("arst_done", 32'(done0 | done1), 32'(0));
    check("arst_gle",  32'({g0, l0, e0, g1, l1, e1}), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    d0 = done_cnt;
    idle_cycles(15);
    check("arst_no_done", 32'(done_cnt - d0), 32'(0));
    check("arst_gle_zero", 32'({g0, l0, e0}), 32'(0));
    run_cmp(8'h01, 8'h02, lat);
    check("post_rst_lat", 32'(lat), 32'(W));
    check("post_rst_l", 32'({g0, l0, e0}), 32'(3'b010));

    // start held high: three back-to-back compares
    idle_cycles(2);
    done_times.delete();
    start = 1'b1; a = 8'h10; b = 8'h20;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
      if (done0) begin
        n++;
        if (n == 1) begin
          check("b2b_1", 32'({g0, l0, e0}), 32'(3'b010));
          a = 8'h20; b = 8'h10;
        end else if (n == 2) begin
          check("b2b_2", 32'({g0, l0, e0}), 32'(3'b100));
          a = 8'h55; b = 8'h55;
        end else begin
          check("b2b_3", 32'({g0, l0, e0}), 32'(3'b001));
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(n), 32'(3));
    idle_cycles(3);
    if (done_times.size() >= 3) begin
      check("b2b_gap1", 32'(done_times[1] - done_times[0]), 32'(W + 2));
      check("b2b_gap2", 32'(done_times[2] - done_times[1]), 32'(W + 2));
    end else begin
      check("b2b_pulses", 32'(done_times.size()), 32'(3));
    end

    idle_cycles(12);
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
